// File: rtl/pixel_stream_writer_if.sv
// Byte-in / BRAM-write-out bundle for the pixel stream writer.
// The slave modport is the writer itself; the master modport is the
// UART receiver side that supplies bytes and watches the write port.
interface pixel_stream_writer_if #(
   parameter int BYTES_PER_PIXEL = 3,
   parameter int ADDR_W          = 18
);
   localparam int DATA_W = 8 * BYTES_PER_PIXEL;
   localparam int CNT_W  = $clog2(BYTES_PER_PIXEL) + 1;

   logic [7:0]        rx_byte;
   logic              rx_valid;
   logic              wr_en;
   logic              wr_we;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              frame_done;
   logic              sync_err;
   logic              busy;
   logic [CNT_W-1:0]  byte_cnt;

   modport master (
      output rx_byte, rx_valid,
      input  wr_en, wr_we, wr_addr, wr_data, frame_done, sync_err, busy, byte_cnt
   );

   modport slave (
      input  rx_byte, rx_valid,
      output wr_en, wr_we, wr_addr, wr_data, frame_done, sync_err, busy, byte_cnt
   );
endinterface

// File: rtl/pixel_stream_writer.sv
// Pixel stream writer: packs received bytes into pixels and writes them
// to frame-buffer BRAM at sequential addresses, one frame at a time.
// A partial pixel left idle for too long is thrown away so the byte
// stream can resynchronise on pixel boundaries.
module pixel_stream_writer #(
   parameter int BYTES_PER_PIXEL = 3,
   parameter int ADDR_W          = 18,
   parameter int FRAME_PIXELS    = 196608,
   parameter bit MSB_FIRST       = 1'b1,
   parameter int TIMEOUT_CYCLES  = 1000000
) (
   input  logic                 clk,
   input  logic                 rst,
   pixel_stream_writer_if.slave bus
);

   localparam int DATA_W = 8 * BYTES_PER_PIXEL;
   localparam int CNT_W  = $clog2(BYTES_PER_PIXEL) + 1;
   localparam int TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
   localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_PIXEL - 1);
   localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0]   TO_ARM    = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] asm_q, asm_d;
   logic [DATA_W-1:0] asm_in;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              wr_en_q, wr_en_d;
   logic              sync_err_q, sync_err_d;
   logic [TO_W-1:0]   idle_q, idle_d;
   logic              timeout_hit;

   // Frame sequencing; a write to the last address always forces DONE
   // so frame_done follows that write by exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.rx_valid) state_d = COLLECT;
         COLLECT: state_d = COLLECT;
         DONE:    state_d = bus.rx_valid ? COLLECT : IDLE;
         default: state_d = IDLE;
      endcase
      if (wr_en_q && (addr_q == LAST_ADDR)) begin
         state_d = DONE;
      end
   end

   // Merge the incoming byte into the assembly word in the configured order.
   always_comb begin
      asm_in = asm_q;
      if (MSB_FIRST) begin
         asm_in = (asm_q << 8) | DATA_W'(bus.rx_byte);
      end else begin
         for (int i = 0; i < BYTES_PER_PIXEL; i++) begin
            if (byte_cnt_q == CNT_W'(i)) begin
               asm_in[8*i +: 8] = bus.rx_byte;
            end
         end
      end
   end

   // Byte counting, pixel completion, address stepping and the idle timeout.
   always_comb begin
      asm_d       = asm_q;
      byte_cnt_d  = byte_cnt_q;
      data_d      = data_q;
      wr_en_d     = 1'b0;
      sync_err_d  = 1'b0;
      addr_d      = addr_q;
      idle_d      = idle_q;
      timeout_hit = TO_EN && (state_q == COLLECT) && !bus.rx_valid && (idle_q == TO_ARM);

      if (wr_en_q) begin
         addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
      end

      if (bus.rx_valid) begin
         asm_d = asm_in;
         if (byte_cnt_q == LAST_BYTE) begin
            data_d     = asm_in;
            wr_en_d    = 1'b1;
            byte_cnt_d = '0;
         end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
         end
      end else if (timeout_hit && (byte_cnt_q != '0)) begin
         asm_d      = '0;
         byte_cnt_d = '0;
         sync_err_d = 1'b1;
      end

      if (!TO_EN || bus.rx_valid || (state_q != COLLECT)) begin
         idle_d = '0;
      end else if (idle_q != TO_LIMIT) begin
         idle_d = idle_q + TO_W'(1);
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         asm_q      <= '0;
         byte_cnt_q <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wr_en_q    <= 1'b0;
         sync_err_q <= 1'b0;
         idle_q     <= '0;
      end else begin
         state_q    <= state_d;
         asm_q      <= asm_d;
         byte_cnt_q <= byte_cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wr_en_q    <= wr_en_d;
         sync_err_q <= sync_err_d;
         idle_q     <= idle_d;
      end
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.wr_we      = wr_en_q;
   assign bus.wr_addr    = addr_q;
   assign bus.wr_data    = data_q;
   assign bus.frame_done = (state_q == DONE);
   assign bus.sync_err   = sync_err_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Testbench for pixel_stream_writer: two instances (MSB-first and
// LSB-first) share one byte stream and are compared every cycle against
// a byte-queue model of pixels, frames and the idle timeout.
module tb_pixel_stream_writer;

   localparam int BPP = 3;
   localparam int AW  = 3;
   localparam int FP  = 4;
   localparam int TO  = 16;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       rxValid = 1'b0;
   logic [7:0] rxByte  = 8'h00;

   int total = 0;
   int bad   = 0;

   logic        eWrEn, eDone, eSync, eBusy;
   int          eAddr, eCnt, quiet;
   logic [31:0] eDataA, eDataB;
   int          pix[$];

   pixel_stream_writer_if #(.BYTES_PER_PIXEL(BPP), .ADDR_W(AW)) busA ();
   pixel_stream_writer_if #(.BYTES_PER_PIXEL(BPP), .ADDR_W(AW)) busB ();

   assign busA.rx_byte  = rxByte;
   assign busA.rx_valid = rxValid;
   assign busB.rx_byte  = rxByte;
   assign busB.rx_valid = rxValid;

   pixel_stream_writer #(
      .BYTES_PER_PIXEL(BPP), .ADDR_W(AW), .FRAME_PIXELS(FP),
      .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(TO)
   ) dutA (
      .clk(clk), .rst(rst), .bus(busA)
   );

   pixel_stream_writer #(
      .BYTES_PER_PIXEL(BPP), .ADDR_W(AW), .FRAME_PIXELS(FP),
      .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(TO)
   ) dutB (
      .clk(clk), .rst(rst), .bus(busB)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("wr_en",      32'(busA.wr_en),      32'(eWrEn));
      checkOutput("wr_we",      32'(busA.wr_we),      32'(eWrEn));
      checkOutput("wr_addr",    32'(busA.wr_addr),    32'(eAddr));
      checkOutput("wr_data_m",  32'(busA.wr_data),    eDataA);
      checkOutput("frame_done", 32'(busA.frame_done), 32'(eDone));
      checkOutput("sync_err",   32'(busA.sync_err),   32'(eSync));
      checkOutput("busy",       32'(busA.busy),       32'(eBusy));
      checkOutput("byte_cnt",   32'(busA.byte_cnt),   32'(eCnt));
      checkOutput("wr_en_l",    32'(busB.wr_en),      32'(eWrEn));
      checkOutput("wr_data_l",  32'(busB.wr_data),    eDataB);
      checkOutput("wr_addr_l",  32'(busB.wr_addr),    32'(eAddr));
   endtask

   task automatic modelReset();
      pix.delete();
      quiet  = 0;
      eWrEn  = 1'b0;
      eDone  = 1'b0;
      eSync  = 1'b0;
      eBusy  = 1'b0;
      eAddr  = 0;
      eCnt   = 0;
      eDataA = 32'h0;
      eDataB = 32'h0;
   endtask

   // One clock cycle: check this cycle's outputs, present a byte (or not),
   // then predict what the writer shows in the following cycle.
   task automatic applyStimulus(input logic v, input logic [7:0] b);
      logic        collecting, nWrEn, nDone, nSync, nBusy;
      int          nAddr;
      logic [31:0] nA, nB;
      @(negedge clk);
      checkAll();
      rxValid = v;
      rxByte  = b;

      collecting = eBusy && !eDone;
      nWrEn = 1'b0;
      nSync = 1'b0;
      nA    = eDataA;
      nB    = eDataB;
      if (v) begin
         pix.push_back(int'(b));
         if (pix.size() == BPP) begin
            nA = 32'h0;
            nB = 32'h0;
            for (int i = 0; i < BPP; i++) begin
               nA = nA | (32'(pix[i]) << (8 * (BPP - 1 - i)));
               nB = nB | (32'(pix[i]) << (8 * i));
            end
            nWrEn = 1'b1;
            pix.delete();
         end
      end else if (collecting && (quiet == TO - 1) && (pix.size() != 0)) begin
         pix.delete();
         nSync = 1'b1;
      end
      if (v || !collecting) quiet = 0;
      else if (quiet < TO)  quiet++;

      nAddr = eWrEn ? (eAddr + 1) % FP : eAddr;
      nDone = eWrEn && (eAddr == FP - 1);
      nBusy = nDone ? 1'b1 : (eDone ? v : (eBusy ? 1'b1 : v));

      eWrEn  = nWrEn;
      eDone  = nDone;
      eSync  = nSync;
      eBusy  = nBusy;
      eAddr  = nAddr;
      eCnt   = pix.size();
      eDataA = nA;
      eDataB = nB;
   endtask

   // Assert reset between clock edges and confirm outputs clear at once.
   task automatic doReset();
      @(negedge clk);
      rxValid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_wr_en",   32'(busA.wr_en),      32'h0);
      checkOutput("rst_wr_we",   32'(busA.wr_we),      32'h0);
      checkOutput("rst_addr",    32'(busA.wr_addr),    32'h0);
      checkOutput("rst_data",    32'(busA.wr_data),    32'h0);
      checkOutput("rst_done",    32'(busA.frame_done), 32'h0);
      checkOutput("rst_sync",    32'(busA.sync_err),   32'h0);
      checkOutput("rst_busy",    32'(busA.busy),       32'h0);
      checkOutput("rst_cnt",     32'(busA.byte_cnt),   32'h0);
      modelReset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Directed scenarios followed by a randomized byte stream.
   initial begin
      modelReset();
      doReset();

      applyStimulus(1'b1, 8'h11);
      applyStimulus(1'b1, 8'h22);
      applyStimulus(1'b1, 8'h33);
      repeat (3) applyStimulus(1'b0, 8'h00);
      checkOutput("first_pix_m", 32'(busA.wr_data),  32'h112233);
      checkOutput("first_pix_l", 32'(busB.wr_data),  32'h332211);
      checkOutput("first_addr",  32'(busA.wr_addr),  32'h1);
      checkOutput("first_cnt",   32'(busA.byte_cnt), 32'h0);

      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
      applyStimulus(1'b0, 8'h00);
      applyStimulus(1'b1, 8'h5A);
      applyStimulus(1'b0, 8'h00);
      checkOutput("done_byte_cnt", 32'(busA.byte_cnt), 32'h1);
      checkOutput("done_addr",     32'(busA.wr_addr),  32'h0);
      checkOutput("done_busy",     32'(busA.busy),     32'h1);

      applyStimulus(1'b1, 8'h77);
      repeat (20) applyStimulus(1'b0, 8'h00);
      checkOutput("to_cnt",  32'(busA.byte_cnt), 32'h0);
      checkOutput("to_addr", 32'(busA.wr_addr),  32'h0);
      applyStimulus(1'b1, 8'hAA);
      applyStimulus(1'b1, 8'hBB);
      applyStimulus(1'b1, 8'hCC);
      repeat (2) applyStimulus(1'b0, 8'h00);
      checkOutput("to_pix",  32'(busA.wr_data), 32'hAABBCC);
      checkOutput("to_next", 32'(busA.wr_addr), 32'h1);

      for (int k = 0; k < 80; k++) begin
         int burst;
         int gap;
         burst = $urandom_range(1, 8);
         for (int j = 0; j < burst; j++) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
         gap = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 22) : $urandom_range(0, 3);
         for (int j = 0; j < gap; j++) applyStimulus(1'b0, 8'h00);
      end

      applyStimulus(1'b1, 8'h99);
      applyStimulus(1'b0, 8'h00);
      doReset();
      applyStimulus(1'b1, 8'h01);
      applyStimulus(1'b1, 8'h02);
      applyStimulus(1'b1, 8'h03);
      repeat (3) applyStimulus(1'b0, 8'h00);
      checkOutput("rst_pix",  32'(busA.wr_data), 32'h010203);
      checkOutput("rst_next", 32'(busA.wr_addr), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
